// File: rtl/div_if.sv
// Handshake and result bundle for the 32-bit divider.
interface div_if;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dz;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, q, r, dz
  );
endinterface

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle, 33-cycle latency.
// Define DIV_ZERO_FAST_EN to resolve a zero divisor in one cycle with the dz flag set.
module div (
  input logic   clk,
  input logic   reset,
  div_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] den_q;
  logic        qneg_q, rneg_q;
  logic [4:0]  cnt_q;
  logic [31:0] q_q, r_q;
  logic        done_q, dz_q;

  logic        busy, accept, fast_zero, load, iter, fix;
  logic        a_neg, b_neg;
  logic [31:0] a_op, b_op;
  logic [32:0] partial;
  logic [33:0] diff;
  logic        qbit;

`ifdef DIV_ZERO_FAST_EN
  logic zf_q;
  assign fast_zero = (bus.divisor == 32'd0);
`else
  assign fast_zero = 1'b0;
`endif

  // Operand conditioning: magnitudes in signed mode, raw values otherwise.
  always_comb begin
    a_neg = bus.sign & bus.dividend[31];
    b_neg = bus.sign & bus.divisor[31];
    a_op  = a_neg ? (~bus.dividend + 32'd1) : bus.dividend;
    b_op  = b_neg ? (~bus.divisor + 32'd1) : bus.divisor;
  end

  // One restoring step on the 33-bit shifted partial remainder.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    diff    = {1'b0, partial} - {2'b00, den_q};
    qbit    = ~diff[33];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !fast_zero) state_d = StCalc;
      StCalc:  if (cnt_q == 5'd31) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A start coinciding with done is dropped, like any start seen while busy.
  always_comb begin
`ifdef DIV_ZERO_FAST_EN
    busy = (state_q != StIdle) | zf_q;
`else
    busy = (state_q != StIdle);
`endif
    accept = bus.start & ~busy & ~done_q;
    load   = (state_q == StIdle) & accept;
    iter   = (state_q == StCalc);
    fix    = (state_q == StFix);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        rem_q  <= '0;
        quo_q  <= a_op;
        den_q  <= b_op;
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt_q  <= '0;
`ifdef DIV_ZERO_FAST_EN
        zf_q   <= fast_zero;
        if (fast_zero) quo_q <= bus.dividend;
`endif
      end
      if (iter) begin
        rem_q <= qbit ? diff[31:0] : partial[31:0];
        quo_q <= {quo_q[30:0], qbit};
        cnt_q <= cnt_q + 5'd1;
      end
      if (fix) begin
        q_q    <= qneg_q ? (~quo_q + 32'd1) : quo_q;
        r_q    <= rneg_q ? (~rem_q + 32'd1) : rem_q;
        dz_q   <= 1'b0;
        done_q <= 1'b1;
      end
`ifdef DIV_ZERO_FAST_EN
      if (zf_q) begin
        q_q    <= '1;
        r_q    <= quo_q;
        dz_q   <= 1'b1;
        done_q <= 1'b1;
        zf_q   <= 1'b0;
      end
`endif
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dz   = dz_q;

endmodule
